sfp_mult_arb: RTL
=================

// Module: sfp_mult_arb
// PURPOSE
//  Round-robin scheduler that shares one sfp_mult pipeline (26-bit sfp: sign[25], exp[24:17], frac[16:0]) among NREQ requesters.
//  Accepts at most one operand pair per clock, issues it into an internal sfp_mult instance and tags it with the requester id.
//  Routes each result back to the originating requester.
//  Sits between the neuron/accumulator engines and the single shared multiplier.
// PARAMETERS
//  NREQ      4   number of requesters (2..8)
//  IDW       2   requester id width, ceil(log2(NREQ))
//  MULT_LAT  4   sfp_mult latency, i_req to o_vld; must match the instantiated sfp_mult
// PORTS
//  i_clk      in   1          clock; single clock domain
//  i_rst      in   1          reset, synchronous, active-low; also drives sfp_mult i_rst
//  i_en       in   1          1 = arbitration enabled; 0 = o_gnt forced 0, in-flight ops still drain
//  i_req      in   NREQ       per-requester valid; operands held stable until granted
//  i_da       in   NREQ*26    operand A, requester k at [26k+25:26k]
//  i_db       in   NREQ*26    operand B, same packing
//  o_gnt      out  NREQ       one-hot ready, combinational; transfer when i_req[k]&o_gnt[k] at a rising edge
//  o_vld      out  NREQ       one-hot result strobe, registered, 1 cycle per result
//  o_do       out  26         result, valid for requester k when o_vld[k]=1; holds last value otherwise
//  o_inflight out  IDW+2      number of ops issued whose result has not yet been returned
//  o_err      out  1          sticky: tag/valid mismatch detected
// BEHAVIOUR
//  Reset (i_rst=0 at an edge):
//   - Clears ptr=0, tag pipe, issue regs, o_vld=0, o_do=0, o_inflight=0, o_err=0.
//   - o_gnt=0 while i_rst=0.
//   - sfp_mult valid chain is cleared by the same reset, so results in flight are discarded and never returned.
//  Arbitration:
//   - Priority order is ptr, ptr+1, ... wrapping mod NREQ.
//   - o_gnt = first set bit of i_req in that order, gated by i_en and i_rst. At most one bit set; o_gnt=0 when i_req=0.
//   - On a transfer to k, ptr <= (k+1) mod NREQ. With no transfer, ptr holds.
//   - Continuous requests from all requesters are served k=0,1,2,3,0,... with one grant per cycle and no bubbles.
//  Issue stage:
//   - On transfer at edge E, m_req/m_da/m_db/m_id register the granted operands, with m_req=1 for one cycle.
//   - Otherwise m_req=0.
//   - The sfp_mult is driven only from these registers.
//  Tag pipe:
//   - MULT_LAT-deep shift of {valid,id}, loaded from {m_req,m_id}.
//   - Its output aligns with sfp_mult o_vld.
//  Return:
//   - When sfp_mult o_vld=1, o_vld[tag_id] <= 1 and o_do <= sfp_mult o_do.
//   - Latency: o_vld[k] is high exactly MULT_LAT+1 clocks after the accepting edge E.
//   - Results return in issue order. There is no backpressure; requesters must always accept.
//  o_inflight:
//   - +1 on transfer, -1 on result, unchanged when both occur in the same cycle.
//   - Range 0..MULT_LAT+1.
//  o_err:
//   - Set when sfp_mult o_vld differs from the tag-pipe valid bit.
//   - Cleared only by reset.
//  i_en falling:
//   - No new grants.
//   - Accepted ops complete normally.
//   - ptr is unchanged.
//  Arithmetic:
//   - Results are exactly sfp_mult's: exp = ea+eb-127 with normalisation.
//   - No overflow or underflow saturation is added here.
// TESTING
//  1. Single op: req0 with 1.0*1.0 (26'h0FF0000 x2) -> o_gnt=0001 same cycle; o_vld=0001 5 clocks later; o_do=26'h0FF0000.
//  2. All four requesting 2.0*1.0 (26'h1010000, 26'h0FF0000) continuously -> grants 0,1,2,3,0 on consecutive cycles; o_vld one-hot in the same order; o_do=26'h1010000.
//  3. ptr fairness: after a grant to 2, requests from 1 and 3 -> 3 is granted first, then 1.
//  4. Reset mid-flight: 3 ops issued, then i_rst=0 for 1 cycle -> o_vld stays 0 thereafter; o_inflight=0; first grant after reset goes to requester 0.
//  5. i_en=0 with 2 ops in flight and i_req=1111 -> o_gnt=0; the 2 results still return; o_inflight goes 2->0; grants resume on i_en=1.
//  6. Random traffic, 10k cycles, against a reference model -> every result matches ptr order and its value; o_err=0; o_inflight never exceeds 5.

Source files
------------

// File: rtl/sfp_mult_arb.sv
// sfp_mult_arb: round-robin share of one sfp_mult pipeline among NREQ
// requesters, with per-op id tags routing each result back to its owner.
//
// Ports:
//   i_clk              clock
//   i_rst              synchronous active-low reset (also resets sfp_mult)
//   i_en               arbitration enable; in-flight ops drain when low
//   i_req[NREQ]        per-requester valid, operands stable until granted
//   i_da/i_db          operands, requester k at [26k+25:26k]
//   o_gnt[NREQ]        one-hot combinational grant
//   o_vld[NREQ]        one-hot registered result strobe
//   o_do[26]           result, holds last value between strobes
//   o_inflight[IDW+2]  ops issued but not yet returned
//   o_err              sticky tag/valid mismatch flag
//
// sfp format: sign[25], exp[24:17] (bias 127), frac[16:0] where frac[16]
// is the explicit leading one (1.0 = 26'h0FF0000).

module sfp_mult #(
    parameter int LAT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic [25:0] i_da,
    input  logic [25:0] i_db,
    output logic        o_vld,
    output logic [25:0] o_do
);
    logic [33:0]    prod;
    logic [7:0]     e_sum;
    logic [25:0]    res;
    logic [LAT-1:0] v;
    logic [25:0]    d [LAT];

    assign prod  = {17'b0, i_da[16:0]} * {17'b0, i_db[16:0]};
    // A product >= 2.0 shifts right by one and bumps the exponent.
    assign e_sum = i_da[24:17] + i_db[24:17] - 8'd127 + {7'b0, prod[33]};
    assign res   = {i_da[25] ^ i_db[25], e_sum,
                    prod[33] ? prod[33:17] : prod[32:16]};

    always_ff @(posedge i_clk) begin
        if (!i_rst) v <= '0;
        else        v <= {v[LAT-2:0], i_req};
    end

    always_ff @(posedge i_clk) begin
        d[0] <= res;
        for (int i = 1; i < LAT; i++) d[i] <= d[i-1];
    end

    assign o_vld = v[LAT-1];
    assign o_do  = d[LAT-1];
endmodule

module sfp_mult_arb #(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int MULT_LAT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ*26-1:0] i_da,
    input  logic [NREQ*26-1:0] i_db,
    output logic [NREQ-1:0]    o_gnt,
    output logic [NREQ-1:0]    o_vld,
    output logic [25:0]        o_do,
    output logic [IDW+1:0]     o_inflight,
    output logic               o_err
);
    localparam int IFW = IDW + 2;

    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      gnt_id;
    logic                gnt_any;
    logic                xfer;
    logic                m_req;
    logic [IDW-1:0]      m_id;
    logic [25:0]         m_da;
    logic [25:0]         m_db;
    logic [MULT_LAT-1:0] t_v;
    logic [IDW-1:0]      t_id [MULT_LAT];
    logic                mv;
    logic [25:0]         md;

    // Scan requesters starting at ptr, wrapping; first hit wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = ptr;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_any && i_req[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
    end

    assign xfer = gnt_any && i_en && i_rst;

    always_comb begin
        o_gnt = '0;
        if (xfer) o_gnt[gnt_id] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            ptr   <= '0;
            m_req <= 1'b0;
            m_id  <= '0;
            m_da  <= '0;
            m_db  <= '0;
        end else begin
            m_req <= xfer;
            if (xfer) begin
                ptr  <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
                m_id <= gnt_id;
                m_da <= i_da[26*gnt_id +: 26];
                m_db <= i_db[26*gnt_id +: 26];
            end
        end
    end

    sfp_mult #(.LAT(MULT_LAT)) u_mult (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req (m_req),
        .i_da  (m_da),
        .i_db  (m_db),
        .o_vld (mv),
        .o_do  (md)
    );

    // Id tags travel alongside the multiplier so they emerge with its result.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            t_v <= '0;
            for (int i = 0; i < MULT_LAT; i++) t_id[i] <= '0;
        end else begin
            t_v     <= {t_v[MULT_LAT-2:0], m_req};
            t_id[0] <= m_id;
            for (int i = 1; i < MULT_LAT; i++) t_id[i] <= t_id[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_vld      <= '0;
            o_do       <= '0;
            o_inflight <= '0;
            o_err      <= 1'b0;
        end else begin
            o_vld <= '0;
            if (mv) begin
                o_vld[t_id[MULT_LAT-1]] <= 1'b1;
                o_do                    <= md;
            end
            if (mv != t_v[MULT_LAT-1]) o_err <= 1'b1;
            case ({xfer, mv})
                2'b10:   o_inflight <= o_inflight + IFW'(1);
                2'b01:   o_inflight <= o_inflight - IFW'(1);
                default: o_inflight <= o_inflight;
            endcase
        end
    end
endmodule
